// File: rtl/multi_laser_tx.sv
// multi_laser_tx: frames per-channel parallel bytes into start/data/stop laser bit streams.
// Latency: accept -> LOAD next cycle, start bit after the first tick seen in LOAD; every bit is divider+1 cycles.
// Backpressure: tx_ready[c] only while channel c is IDLE and en=1; in sync mode only when all are IDLE and all tx_valid are high.
// Optional feature: define LASER_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
// Ports: clock; reset (synchronous, active-high); en (low aborts every channel); divider (bit period - 1);
//        sync_mode; tx_data/tx_valid/tx_ready (per-channel byte handshake, channel c at [c*DATA_W +: DATA_W]);
//        laser_out (registered line drive, idle 0); done (one-cycle pulse in the final cycle of each stop bit).
module multi_laser_tx #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  input  logic [DIV_W-1:0]             divider,
  input  logic                         sync_mode,
  input  logic [CHANNELS*DATA_W-1:0]   tx_data,
  input  logic [CHANNELS-1:0]          tx_valid,
  output logic [CHANNELS-1:0]          tx_ready,
  output logic [CHANNELS-1:0]          laser_out,
  output logic [CHANNELS-1:0]          done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  state_e             state_q [CHANNELS];
  state_e             state_d [CHANNELS];
  logic [DATA_W-1:0]  shreg_q [CHANNELS];
  logic [DATA_W-1:0]  shreg_d [CHANNELS];
  logic [IDX_W-1:0]   idx_q   [CHANNELS];
  logic [IDX_W-1:0]   idx_d   [CHANNELS];
  logic [CHANNELS-1:0] laser_q, laser_d;
`ifdef LASER_TX_PARITY_EN
  logic [CHANNELS-1:0] par_q, par_d;
`endif
  logic [CHANNELS-1:0] idle;
  logic [CHANNELS-1:0] accept;
  logic                all_go;

  // Shared baud tick; '>=' lets a lowered divider take effect at the very next compare.
  always_comb begin
    tick  = en && (cnt_q >= divider);
    cnt_d = (!en || tick) ? '0 : cnt_q + DIV_W'(1);
  end

  // Ready is gated by reset so the handshake is quiet while the block is held in reset.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      idle[c] = (state_q[c] == S_IDLE);
    end
    all_go = en && (&idle) && (&tx_valid);
    for (int c = 0; c < CHANNELS; c++) begin
      tx_ready[c] = !reset && (sync_mode ? all_go : (en && idle[c]));
    end
    accept = tx_ready & tx_valid;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      shreg_d[c] = shreg_q[c];
      idx_d[c]   = idx_q[c];
`ifdef LASER_TX_PARITY_EN
      par_d[c]   = par_q[c];
`endif
      done[c]    = 1'b0;
      if (!en) begin
        // Abort: captured data is dropped, no done pulse.
        state_d[c] = S_IDLE;
        shreg_d[c] = '0;
        idx_d[c]   = '0;
`ifdef LASER_TX_PARITY_EN
        par_d[c]   = 1'b0;
`endif
      end else begin
        case (state_q[c])
          S_IDLE: begin
            if (accept[c]) begin
              shreg_d[c] = tx_data[c*DATA_W +: DATA_W];
`ifdef LASER_TX_PARITY_EN
              par_d[c]   = ^tx_data[c*DATA_W +: DATA_W];
`endif
              state_d[c] = S_LOAD;
            end
          end
          S_LOAD: begin
            if (tick) state_d[c] = S_START;
          end
          S_START: begin
            if (tick) begin
              state_d[c] = S_DATA;
              idx_d[c]   = IDX_W'(DATA_W - 1);
            end
          end
          S_DATA: begin
            if (tick) begin
              if (idx_q[c] == '0) begin
`ifdef LASER_TX_PARITY_EN
                state_d[c] = S_PARITY;
`else
                state_d[c] = S_STOP;
`endif
              end else begin
                // MSB-first: the line always shows shreg[MSB].
                idx_d[c]   = idx_q[c] - IDX_W'(1);
                shreg_d[c] = shreg_q[c] << 1;
              end
            end
          end
`ifdef LASER_TX_PARITY_EN
          S_PARITY: begin
            if (tick) state_d[c] = S_STOP;
          end
`endif
          S_STOP: begin
            if (tick) begin
              state_d[c] = S_IDLE;
              done[c]    = !reset;
            end
          end
          default: state_d[c] = S_IDLE;
        endcase
      end

      // Line is registered from the next state so laser_out lines up with state_q.
      case (state_d[c])
        S_START: laser_d[c] = 1'b1;
        S_DATA:  laser_d[c] = shreg_d[c][DATA_W-1];
`ifdef LASER_TX_PARITY_EN
        S_PARITY: laser_d[c] = par_d[c];
`endif
        default: laser_d[c] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      laser_q <= '0;
`ifdef LASER_TX_PARITY_EN
      par_q   <= '0;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        shreg_q[c] <= '0;
        idx_q[c]   <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      laser_q <= laser_d;
`ifdef LASER_TX_PARITY_EN
      par_q   <= par_d;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        shreg_q[c] <= shreg_d[c];
        idx_q[c]   <= idx_d[c];
      end
    end
  end

  assign laser_out = laser_q;

endmodule

// File: tb/tb_multi_laser_tx.sv
module tb_multi_laser_tx;

`ifdef LASER_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  divider = 8'd0;
  logic        sync_mode = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic [1:0]  tx_valid = 2'b00;
  logic [1:0]  tx_ready;
  logic [1:0]  laser_out;
  logic [1:0]  done;

  multi_laser_tx #(.CHANNELS(2), .DATA_W(8), .DIV_W(8)) dut (
    .clock(clock), .reset(reset), .en(en), .divider(divider), .sync_mode(sync_mode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .laser_out(laser_out), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int acc; int per; } exp_t;
  exp_t expq0[$];
  exp_t expq1[$];

  int checks = 0;
  int failures = 0;
  int cur_div = 0;

  bit cap [2][512];
  int cap_len [2];
  bit inframe [2];
  int start_last [2];
  int done_last [2];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference frame: start 1, payload MSB first, optional even parity, stop 0.
  function automatic bit exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b1;
    if (b <= 8) return d[8-b];
    if (b == 9 && NB == 11) return ^d;
    return 1'b0;
  endfunction

  task automatic score(input int c);
    exp_t e;
    int bad;
    int lat;
    int total;
    checks++;
    if ((c == 0 && expq0.size() == 0) || (c == 1 && expq1.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_done ch%0d actual=done required=no_done (cycle %0d)", c, cyc);
      return;
    end
    if (c == 0) e = expq0.pop_front();
    else        e = expq1.pop_front();
    total = NB * e.per;
    chk($sformatf("frame_len_ch%0d", c), cap_len[c], total);
    bad = 0;
    for (int i = 0; i < cap_len[c] && i < total; i++) begin
      if (cap[c][i] != exp_bit(e.data, i / e.per)) bad++;
    end
    chk($sformatf("frame_bits_ch%0d_data%02h", c, e.data), bad, 0);
    lat = start_last[c] - e.acc;
    checks++;
    if (lat < 2 || lat > e.per + 1) begin
      failures++;
      $display("FAIL start_latency_ch%0d actual=%0d required=2..%0d", c, lat, e.per + 1);
    end
  endtask

  // Monitor: captures each channel's line from the start edge up to done, then scores.
  always @(negedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (reset || !en) begin
        inframe[c] = 1'b0;
        cap_len[c] = 0;
        if (done[c]) begin
          checks++;
          failures++;
          $display("FAIL done_while_disabled ch%0d actual=1 required=0 (cycle %0d)", c, cyc);
        end
      end else begin
        if (!inframe[c] && laser_out[c]) begin
          inframe[c]    = 1'b1;
          cap_len[c]    = 0;
          start_last[c] = cyc;
        end
        if (inframe[c] && cap_len[c] < 512) begin
          cap[c][cap_len[c]] = laser_out[c];
          cap_len[c]++;
        end
        if (done[c]) begin
          done_last[c] = cyc;
          score(c);
          inframe[c] = 1'b0;
          cap_len[c] = 0;
        end
      end
    end
  end

  task automatic push(input int c, input logic [7:0] d, input int acc);
    exp_t e;
    e.data = d;
    e.acc  = acc;
    e.per  = cur_div + 1;
    if (c == 0) expq0.push_back(e);
    else        expq1.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int c, input logic [7:0] d, output int acc);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    acc = -1;
    @(posedge clock);
    #1;
    tx_data[c*8 +: 8] = d;
    tx_valid[c] = 1'b1;
    while (!got && n < 200) begin
      @(negedge clock);
      if (tx_ready[c]) got = 1'b1;
      else n++;
    end
    chk($sformatf("accept_ch%0d", c), int'(got), 1);
    if (got) begin
      acc = cyc;
      push(c, d, acc);
    end
    @(posedge clock);
    #1;
    tx_valid[c] = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((expq0.size() + expq1.size()) != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk(name, expq0.size() + expq1.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic set_div(input int d);
    divider = 8'(d);
    cur_div = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int ones;
    int seen;
    logic [7:0] d0, d1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_laser", laser_out, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", tx_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("en0_ready", tx_ready, 0);
    @(posedge clock); #1;
    en = 1'b1;
    set_div(0);

    // divider=0, ch0 8'hC8: exact cycle placement
    send(0, 8'hC8, acc);
    @(negedge clock);
    chk("load_line", laser_out[0], 0);
    chk("load_not_ready", tx_ready[0], 0);
    ones = 0;
    while (cyc < acc + 12) begin
      @(negedge clock);
      if (laser_out[1]) ones++;
      if (cyc == acc + 10) chk("no_early_done", done[0], 0);
      if (cyc == acc + 11) begin
        chk("done_at_11", done[0], 1);
        chk("stop_not_ready", tx_ready[0], 0);
      end
    end
    chk("ready_at_12", tx_ready[0], 1);
    chk("ch1_quiet", ones, 0);
    drain("drain_c8", 50);

    // divider=3, ch1 8'h77
    set_div(3);
    send(1, 8'h77, acc);
    drain("drain_77", 100);
    chk("len40_done_minus_start", done_last[1] - start_last[1] + 1, 40);

    // Randomized independent traffic over several dividers
    for (int k = 0; k < 3; k++) begin
      set_div(k == 0 ? 1 : (k == 1 ? 2 : 0));
      fork
        begin
          int a;
          for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clock);
            send(0, 8'($urandom), a);
          end
        end
        begin
          int a;
          for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clock);
            send(1, 8'($urandom), a);
          end
        end
      join
      drain($sformatf("drain_rand%0d", k), 300);
    end

    // Sync mode: partial valid never accepts
    set_div(0);
    sync_mode = 1'b1;
    tx_data[7:0] = 8'h12;
    tx_valid = 2'b01;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (tx_ready != 2'b00) seen++;
    end
    chk("sync_partial_ready", seen, 0);
    chk("sync_partial_line", laser_out, 0);
    @(posedge clock); #1;
    tx_data[15:8] = 8'h34;
    tx_valid = 2'b11;
    @(negedge clock);
    chk("sync_ready_both", tx_ready, 3);
    if (tx_ready == 2'b11) begin
      push(0, 8'h12, cyc);
      push(1, 8'h34, cyc);
    end
    @(posedge clock); #1;
    tx_valid = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    sync_mode = 1'b0;
    drain("drain_sync", 100);
    chk("sync_start_align", start_last[0], start_last[1]);
    chk("sync_done_align", done_last[0], done_last[1]);

    // Randomized sync frames with a slower bit period
    set_div(2);
    for (int i = 0; i < 3; i++) begin
      sync_mode = 1'b1;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      tx_data = {d1, d0};
      tx_valid = 2'b11;
      seen = 0;
      for (int n = 0; n < 50 && seen == 0; n++) begin
        @(negedge clock);
        if (tx_ready == 2'b11) seen = 1;
      end
      chk("sync_rand_accept", seen, 1);
      if (seen == 1) begin
        push(0, d0, cyc);
        push(1, d1, cyc);
      end
      @(posedge clock); #1;
      tx_valid = 2'b00;
      sync_mode = 1'b0;
      drain("drain_sync_rand", 200);
      chk("sync_rand_align", start_last[0], start_last[1]);
    end

    // en drop mid-DATA, then restart with tx_valid held
    set_div(3);
    send(0, 8'hFF, acc);
    goto(acc + 25);
    en = 1'b0;
    expq0.delete();
    @(negedge clock);
    chk("pre_abort_line", laser_out[0], 1);
    goto(acc + 26);
    @(negedge clock);
    chk("abort_line", laser_out[0], 0);
    chk("abort_ready", tx_ready, 0);
    tx_data[7:0] = 8'hA5;
    tx_valid[0] = 1'b1;
    ones = 0;
    repeat (3) begin
      @(negedge clock);
      if (done != 2'b00 || laser_out != 2'b00) ones++;
    end
    chk("abort_quiet", ones, 0);
    @(posedge clock); #1;
    en = 1'b1;
    @(negedge clock);
    chk("restart_ready", tx_ready[0], 1);
    acc2 = cyc;
    if (tx_ready[0]) push(0, 8'hA5, acc2);
    @(posedge clock); #1;
    tx_valid[0] = 1'b0;
    drain("drain_restart", 100);
    // Counter held at 0 while disabled: first tick lands divider cycles after re-enable.
    chk("restart_latency", start_last[0] - acc2, 4);

    // Reset during STOP
    set_div(0);
    send(1, 8'h5A, acc);
    goto(acc + 11);
    reset = 1'b1;
    expq1.delete();
    @(negedge clock);
    chk("reset_stop_no_done", done[1], 0);
    goto(acc + 12);
    @(negedge clock);
    chk("reset_laser", laser_out, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", tx_ready, 0);
    goto(acc + 13);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_ready", tx_ready, 3);
    send(1, 8'($urandom), acc);
    send(0, 8'($urandom), acc);
    drain("drain_post_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
